// File: rtl/avalon_st_sink_fifo_pkg.sv
// avalon_st_pkg: beat type and handshake constants shared with the upstream 8-bit source
package avalon_st_pkg;
    parameter int DATA_W = 8;
    typedef logic [DATA_W-1:0] beat_t;
    localparam int READY_LATENCY = 0;
endpackage

// File: rtl/avalon_st_sink_fifo_if.sv
// avalon_st_if: valid/ready/data beat channel; master drives the beat, slave drives ready
interface avalon_st_if import avalon_st_pkg::*; #(
    parameter int DATA_W = avalon_st_pkg::DATA_W
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    modport master (output valid, data, input ready);
    modport slave (input valid, data, output ready);
endinterface

// File: rtl/avalon_st_sink_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO; full/empty come from the level counter, not pointer compare
module sync_fifo_fwft #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;
    assign full    = level == (AW + 1)'(DEPTH);
    assign empty   = level == '0;
    assign push    = wr_en & ~full;
    assign pop     = rd_en & ~empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push != pop) level <= push ? level + 1'b1 : level - 1'b1;
        end
    end
    // memory is left uncleared by reset; the zeroed level hides stale entries
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/avalon_st_sink_fifo.sv
// avalon_st_sink_fifo: Avalon-ST sink buffering beats in a FWFT FIFO, with beat count and data sum statistics
module avalon_st_sink_fifo import avalon_st_pkg::*; #(
    parameter int DATA_W = avalon_st_pkg::DATA_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    avalon_st_if.slave             snk,
    avalon_st_if.master            src,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       beat_count,
    output logic [CNT_W-1:0]       data_sum
);
    if (READY_LATENCY != 0) begin : g_bad_rl
        $error("sink only supports ready latency 0");
    end
    logic full, empty, push;
    // ready comes from registered level only, so out_ready never reaches in_ready
    assign snk.ready = ~full;
    assign src.valid = ~empty;
    assign push      = snk.valid & snk.ready;
    sync_fifo_fwft #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .wr_en  (snk.valid),
        .wr_data(snk.data),
        .rd_en  (src.ready),
        .rd_data(src.data),
        .full   (full),
        .empty  (empty),
        .level  (level)
    );
    always_ff @(posedge clk) begin
        if (!resetn) begin
            beat_count <= '0;
            data_sum   <= '0;
        end else if (push) begin
            if (beat_count != '1) beat_count <= beat_count + 1'b1;
            data_sum <= data_sum + CNT_W'(snk.data);
        end
    end
endmodule

// File: tb/tb_avalon_st_sink_fifo.sv
// tb_avalon_st_sink_fifo: directed scoreboard bench for the Avalon-ST sink FIFO (16-bit and 4-bit statistics)
module tb_avalon_st_sink_fifo;
    logic        clk = 0;
    logic        resetn;
    logic [2:0]  level0, level1;
    logic [15:0] bc0, sum0;
    logic [3:0]  bc1, sum1;
    int          total = 0;
    int          bad = 0;
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    avalon_st_if #(.DATA_W(8)) s0 ();
    avalon_st_if #(.DATA_W(8)) d0 ();
    avalon_st_if #(.DATA_W(8)) s1 ();
    avalon_st_if #(.DATA_W(8)) d1 ();
    always #5 clk = ~clk;
    avalon_st_sink_fifo #(.DATA_W(8), .DEPTH(4), .CNT_W(16)) dut0 (
        .clk(clk), .resetn(resetn), .snk(s0), .src(d0),
        .level(level0), .beat_count(bc0), .data_sum(sum0)
    );
    avalon_st_sink_fifo #(.DATA_W(8), .DEPTH(4), .CNT_W(4)) dut1 (
        .clk(clk), .resetn(resetn), .snk(s1), .src(d1),
        .level(level1), .beat_count(bc1), .data_sum(sum1)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic put0(input logic [7:0] v);
        s0.valid = 1;
        s0.data  = v;
        q0.push_back(v);
        step();
    endtask
    // pop side of the scoreboards: every output handshake must match the oldest expected beat
    always @(posedge clk) begin
        if (resetn && d0.valid && d0.ready) begin
            if (q0.size() == 0) chk("sb0_empty", {24'h0, d0.data}, 32'hdead);
            else chk("sb0_data", {24'h0, d0.data}, {24'h0, q0.pop_front()});
        end
        if (resetn && d1.valid && d1.ready) begin
            if (q1.size() == 0) chk("sb1_empty", {24'h0, d1.data}, 32'hdead);
            else chk("sb1_data", {24'h0, d1.data}, {24'h0, q1.pop_front()});
        end
    end
    initial begin
        resetn = 0;
        s0.valid = 0; s0.data = 'x; d0.ready = 0;
        s1.valid = 0; s1.data = 'x; d1.ready = 1;
        repeat (2) step();
        resetn = 1;
        chk("rst_in_ready", {31'h0, s0.ready}, 1);
        chk("rst_out_valid", {31'h0, d0.valid}, 0);
        chk("rst_out_data", {24'h0, d0.data}, 0);
        chk("rst_level", {29'h0, level0}, 0);
        chk("rst_bc", {16'h0, bc0}, 0);
        chk("rst_sum", {16'h0, sum0}, 0);
        d0.ready = 1;
        put0(8'd4);
        chk("lat_valid4", {31'h0, d0.valid}, 1);
        chk("lat_data4", {24'h0, d0.data}, 4);
        put0(8'd5);
        chk("lat_data5", {24'h0, d0.data}, 5);
        chk("lat_level5", {29'h0, level0}, 1);
        put0(8'd6);
        chk("lat_data6", {24'h0, d0.data}, 6);
        s0.valid = 0; s0.data = 'x;
        step();
        step();
        chk("str_level", {29'h0, level0}, 0);
        chk("str_out_valid", {31'h0, d0.valid}, 0);
        chk("str_out_data", {24'h0, d0.data}, 0);
        chk("str_bc", {16'h0, bc0}, 3);
        chk("str_sum_x_idle", {16'h0, sum0}, 15);
        d0.ready = 0;
        for (int i = 4; i <= 7; i++) put0(8'(i));
        s0.data = 8'd8;
        step();
        chk("bp_level_full", {29'h0, level0}, 4);
        chk("bp_in_ready_full", {31'h0, s0.ready}, 0);
        chk("bp_bc_held", {16'h0, bc0}, 7);
        d0.ready = 1;
        step();
        d0.ready = 0;
        chk("bp_level_pop", {29'h0, level0}, 3);
        chk("bp_in_ready_back", {31'h0, s0.ready}, 1);
        q0.push_back(8'd8);
        step();
        s0.valid = 0; s0.data = 'x;
        chk("bp_level_refill", {29'h0, level0}, 4);
        chk("bp_bc", {16'h0, bc0}, 8);
        chk("bp_sum", {16'h0, sum0}, 45);
        d0.ready = 1;
        repeat (4) step();
        d0.ready = 0;
        chk("bp_drained", {29'h0, level0}, 0);
        put0(8'd4);
        put0(8'd5);
        chk("sim_level_pre", {29'h0, level0}, 2);
        chk("sim_head_pre", {24'h0, d0.data}, 4);
        d0.ready = 1;
        put0(8'd6);
        s0.valid = 0; s0.data = 'x; d0.ready = 0;
        chk("sim_level", {29'h0, level0}, 2);
        chk("sim_head", {24'h0, d0.data}, 5);
        chk("sim_bc", {16'h0, bc0}, 11);
        chk("sim_sum", {16'h0, sum0}, 60);
        d0.ready = 1;
        repeat (2) step();
        d0.ready = 0;
        chk("sim_drained", {29'h0, level0}, 0);
        put0(8'd4);
        put0(8'd5);
        chk("mrst_level_pre", {29'h0, level0}, 2);
        resetn = 0;
        s0.valid = 1; s0.data = 8'd6;
        step();
        q0.delete();
        resetn = 1;
        s0.valid = 0; s0.data = 'x;
        chk("mrst_level", {29'h0, level0}, 0);
        chk("mrst_bc", {16'h0, bc0}, 0);
        chk("mrst_sum", {16'h0, sum0}, 0);
        chk("mrst_out_valid", {31'h0, d0.valid}, 0);
        chk("mrst_in_ready", {31'h0, s0.ready}, 1);
        step();
        chk("mrst_level_after", {29'h0, level0}, 0);
        chk("mrst_bc_after", {16'h0, bc0}, 0);
        chk("sat_bc_start", {28'h0, bc1}, 0);
        s1.valid = 1; s1.data = 8'hff;
        for (int i = 0; i < 16; i++) begin
            chk("sat_in_ready", {31'h0, s1.ready}, 1);
            q1.push_back(8'hff);
            step();
            if (i == 14) begin
                chk("sat_bc15", {28'h0, bc1}, 15);
                chk("sat_sum15", {28'h0, sum1}, 1);
            end
        end
        s1.valid = 0; s1.data = 'x;
        chk("sat_bc_hold", {28'h0, bc1}, 15);
        chk("sat_sum_wrap", {28'h0, sum1}, 0);
        repeat (2) step();
        chk("sat_level", {29'h0, level1}, 0);
        chk("sb0_left", q0.size(), 0);
        chk("sb1_left", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
